// File: rtl/ss_request_seq_pkg.sv
// ---------------------------------------------------------------------------
// ss_seq_pkg
// Shared types and constants for the savestate request sequencer:
//   - ss_state_e : sequencer FSM states
//   - ss_op_e    : requested operation (save / load)
//   - ss_req_t   : one captured request (valid, op, slot)
//   - INFO_*     : result message codes reported on info/info_req
//   - done_info(): completion code for a finished operation
// ---------------------------------------------------------------------------
package ss_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PAUSE  = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    RESUME = 3'd4
  } ss_state_e;

  typedef enum logic {
    OP_SAVE = 1'b0,
    OP_LOAD = 1'b1
  } ss_op_e;

  typedef struct packed {
    logic       valid;
    ss_op_e     op;
    logic [1:0] slot;
  } ss_req_t;

  localparam logic [7:0] INFO_SAVE_BASE = 8'h14;
  localparam logic [7:0] INFO_LOAD_BASE = 8'h18;
  localparam logic [7:0] INFO_TIMEOUT   = 8'h1C;
  localparam logic [7:0] INFO_REJECT    = 8'h1D;

  // Completion code: base for the operation plus the slot number.
  function automatic logic [7:0] done_info(input ss_op_e op, input logic [1:0] slot);
    logic [7:0] base;
    base = (op == OP_SAVE) ? INFO_SAVE_BASE : INFO_LOAD_BASE;
    return base + {6'd0, slot};
  endfunction

endpackage

// File: rtl/ss_request_seq_if.sv
// ---------------------------------------------------------------------------
// ss_request_seq_if
// Bundles every signal between the sequencer and its surroundings (savestate
// UI, core pause handshake, savestate engine, status reporting).
//   master : the sequencer (drives pause_req, start_*, busy, info*, slot_full)
//   slave  : the environment (drives ss_save/ss_load/ss_slot, pause_ack,
//            eng_done)
// ---------------------------------------------------------------------------
interface ss_request_seq_if;

  logic       ss_save;
  logic       ss_load;
  logic [1:0] ss_slot;
  logic       pause_req;
  logic       pause_ack;
  logic       start_save;
  logic       start_load;
  logic [1:0] start_slot;
  logic       eng_done;
  logic       busy;
  logic       info_req;
  logic [7:0] info;
  logic [3:0] slot_full;

  modport master (
    input  ss_save, ss_load, ss_slot, pause_ack, eng_done,
    output pause_req, start_save, start_load, start_slot,
           busy, info_req, info, slot_full
  );

  modport slave (
    output ss_save, ss_load, ss_slot, pause_ack, eng_done,
    input  pause_req, start_save, start_load, start_slot,
           busy, info_req, info, slot_full
  );

endinterface

// File: rtl/ss_request_seq_watchdog.sv
// ---------------------------------------------------------------------------
// ss_seq_watchdog
// Handshake watchdog shared by all waiting states of the sequencer.
//   clk     : rising-edge clock
//   reset   : synchronous, active-high; clears the counter
//   clear   : high in the first cycle of a state; restarts the count from 0
//   enable  : count this cycle
//   expired : high in the cycle whose count sets the counter MSB, so the
//             owner reacts on the same edge the MSB sets
// A state that stays enabled for 2**(TIMEOUT_BITS-1) cycles sees expired in
// its last cycle.
// ---------------------------------------------------------------------------
module ss_seq_watchdog #(
  parameter int TIMEOUT_BITS = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_BITS-1:0] cnt_q;
  logic [TIMEOUT_BITS-1:0] cnt_base;
  logic [TIMEOUT_BITS-1:0] cnt_inc;

  // The stored count belongs to the previous state while clear is high.
  assign cnt_base = clear ? '0 : cnt_q;
  assign cnt_inc  = cnt_base + TIMEOUT_BITS'(1);
  assign expired  = enable & cnt_inc[TIMEOUT_BITS-1];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_inc;
    end else begin
      cnt_q <= cnt_base;
    end
  end

endmodule

// File: rtl/ss_request_seq.sv
// ---------------------------------------------------------------------------
// ss_request_seq
// Sequences a savestate save/load: pause the core, start the engine, wait for
// completion, resume the core and report a result code.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : ss_request_seq_if.master
//     ss_save/ss_load/ss_slot : one-cycle UI request pulses + slot
//     pause_req/pause_ack     : core halt handshake (levels)
//     start_save/start_load   : one-cycle engine start pulses
//     start_slot              : latched slot, valid while busy
//     eng_done                : one-cycle engine completion pulse
//     busy                    : high outside IDLE
//     info_req/info           : one-cycle result pulse + message code
//     slot_full               : per-slot "contains data" flags
// Parameter TIMEOUT_BITS sets the watchdog width (fires on counter MSB).
// Optional feature macro SS_SLOTGUARD_EN: track saved slots and reject loads
// from empty slots. Without it slot_full reads 4'hF and all loads proceed.
// ---------------------------------------------------------------------------
module ss_request_seq
  import ss_seq_pkg::*;
#(
  parameter int TIMEOUT_BITS = 24
) (
  input logic               clk,
  input logic               reset,
  ss_request_seq_if.master  bus
);

  ss_state_e  state_q;
  ss_state_e  state_prev_q;
  ss_req_t    pend_q;
  ss_req_t    req_in;
  ss_req_t    take;
  ss_op_e     op_q;
  logic [1:0] slot_q;
  logic       pause_req_q;
  logic       busy_q;
  logic       start_save_q;
  logic       start_load_q;
  logic       info_req_q;
  logic [7:0] info_q;
  logic       reject;
  logic       wd_clear;
  logic       wd_en;
  logic       wd_expired;

  // Decode the UI pulses; a simultaneous save+load is a save. A fresh pulse
  // in IDLE is newer than anything pending, so it wins.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    req_in       = '0;
    req_in.valid = bus.ss_save | bus.ss_load;
    req_in.op    = bus.ss_save ? OP_SAVE : OP_LOAD;
    req_in.slot  = bus.ss_slot;
    take         = req_in.valid ? req_in : pend_q;
  end

  // The watchdog restarts on every state entry; states never re-enter
  // themselves, so a state change marks the first cycle of a state.
  assign wd_clear = (state_q != state_prev_q);
  assign wd_en    = (state_q == PAUSE) || (state_q == RUN) || (state_q == RESUME);

  ss_seq_watchdog #(
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

`ifdef SS_SLOTGUARD_EN
  logic [3:0] slot_full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_full_q <= '0;
    end else if ((state_q == RUN) && bus.eng_done && (op_q == OP_SAVE)) begin
      slot_full_q[slot_q] <= 1'b1;
    end
  end

  assign reject        = take.valid && (take.op == OP_LOAD) && !slot_full_q[take.slot];
  assign bus.slot_full = slot_full_q;
`else
  assign reject        = 1'b0;
  assign bus.slot_full = 4'hF;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      state_prev_q <= IDLE;
      pend_q       <= '0;
      op_q         <= OP_SAVE;
      slot_q       <= '0;
      pause_req_q  <= 1'b0;
      busy_q       <= 1'b0;
      start_save_q <= 1'b0;
      start_load_q <= 1'b0;
      info_req_q   <= 1'b0;
      info_q       <= '0;
    end else begin
      state_prev_q <= state_q;
      start_save_q <= 1'b0;
      start_load_q <= 1'b0;
      info_req_q   <= 1'b0;

      // Any request seen outside IDLE (including the eng_done cycle and the
      // RESUME->IDLE edge) lands in the depth-1 pending slot; newest wins.
      if ((state_q != IDLE) && req_in.valid) begin
        pend_q <= req_in;
      end

      unique case (state_q)
        IDLE: begin
          pend_q.valid <= 1'b0;
          if (take.valid) begin
            if (reject) begin
              info_q     <= INFO_REJECT;
              info_req_q <= 1'b1;
            end else begin
              state_q     <= PAUSE;
              op_q        <= take.op;
              slot_q      <= take.slot;
              pause_req_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
        end

        PAUSE: begin
          if (wd_expired) begin
            state_q     <= RESUME;
            pause_req_q <= 1'b0;
            info_q      <= INFO_TIMEOUT;
            info_req_q  <= 1'b1;
          end else if (bus.pause_ack) begin
            state_q      <= START;
            start_save_q <= (op_q == OP_SAVE);
            start_load_q <= (op_q == OP_LOAD);
          end
        end

        START: begin
          state_q <= RUN;
        end

        RUN: begin
          // A completion in the same cycle as expiry still reports success.
          if (bus.eng_done) begin
            state_q     <= RESUME;
            pause_req_q <= 1'b0;
            info_q      <= done_info(op_q, slot_q);
            info_req_q  <= 1'b1;
          end else if (wd_expired) begin
            state_q     <= RESUME;
            pause_req_q <= 1'b0;
            info_q      <= INFO_TIMEOUT;
            info_req_q  <= 1'b1;
          end
        end

        RESUME: begin
          if (wd_expired) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            info_q     <= INFO_TIMEOUT;
            info_req_q <= 1'b1;
          end else if (!bus.pause_ack) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          pause_req_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pause_req  = pause_req_q;
  assign bus.busy       = busy_q;
  assign bus.start_save = start_save_q;
  assign bus.start_load = start_load_q;
  assign bus.start_slot = slot_q;
  assign bus.info_req   = info_req_q;
  assign bus.info       = info_q;

endmodule
